// File: rtl/load_store_unit.sv
// Load/store unit: byte/halfword/word accesses to a big-endian word-wide data memory.
// Each access is a single read-modify-write over one aligned word, with registered memory strobes.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 400
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Req,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        SignExt,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] RData,
    output logic        Fault,
    output logic        mRD,
    output logic        mWR,
    output logic [31:0] mAddr,
    output logic [31:0] mDataOut,
    input  logic [31:0] mDataIn
);

    localparam int unsigned XW = 33;
    localparam logic [XW-1:0] LAST_BYTE = XW'(MEM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_sext;
    logic [1:0]  lat_off;
    logic [31:0] lat_wdata;

    logic [XW-1:0] last_c;
    logic          illegal_c;

    // Select the addressed lane of a big-endian word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                                 input logic [1:0] off, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (sz)
            2'b00:   r = {{24{sx & b[7]}}, b};
            2'b01:   r = {{16{sx & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of the captured word with right-aligned store data.
    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] r;
        r = w;
        case (sz)
            2'b00: begin
                case (off)
                    2'd0:    r[31:24] = wd[7:0];
                    2'd1:    r[23:16] = wd[7:0];
                    2'd2:    r[15:8]  = wd[7:0];
                    default: r[7:0]   = wd[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) r[15:0] = wd[15:0];
                else        r[31:16] = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    // Legality of the request on the input pins; the last-byte test is widened to avoid wrap.
    always_comb begin
        last_c    = {1'b0, Addr[31:2], 2'b11};
        illegal_c = 1'b0;
        case (Size)
            2'b01:   illegal_c = Addr[0];
            2'b10:   illegal_c = |Addr[1:0];
            2'b11:   illegal_c = 1'b1;
            default: illegal_c = 1'b0;
        endcase
        if (last_c > LAST_BYTE) illegal_c = 1'b1;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Fault     <= 1'b0;
            RData     <= '0;
            mRD       <= 1'b1;
            mWR       <= 1'b1;
            mAddr     <= '0;
            mDataOut  <= '0;
            lat_write <= 1'b0;
            lat_size  <= '0;
            lat_sext  <= 1'b0;
            lat_off   <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    Done  <= 1'b0;
                    Fault <= 1'b0;
                    if (Req) begin
                        lat_write <= MemWrite;
                        lat_size  <= Size;
                        lat_sext  <= SignExt;
                        lat_off   <= Addr[1:0];
                        lat_wdata <= WData;
                        Busy      <= 1'b1;
                        if (illegal_c) begin
                            Done  <= 1'b1;
                            Fault <= 1'b1;
                            state <= DONE;
                        end else begin
                            mRD   <= 1'b0;
                            mAddr <= {Addr[31:2], 2'b00};
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    mRD <= 1'b1;
                    if (lat_write) begin
                        mDataOut <= store_merge(mDataIn, lat_wdata, lat_size, lat_off);
                        mWR      <= 1'b0;
                        state    <= WRITE;
                    end else begin
                        RData <= load_extract(mDataIn, lat_size, lat_off, lat_sext);
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                WRITE: begin
                    mWR   <= 1'b1;
                    Done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    Done  <= 1'b0;
                    Fault <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory model, per-cycle output checks and directed accesses.
module tb_load_store_unit;

    localparam int unsigned MEM_BYTES = 400;
    localparam int unsigned NWORDS = MEM_BYTES / 4;

    logic        CLK;
    logic        Reset;
    logic        Req;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        SignExt;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic        Busy;
    logic        Done;
    logic [31:0] RData;
    logic        Fault;
    logic        mRD;
    logic        mWR;
    logic [31:0] mAddr;
    logic [31:0] mDataOut;
    logic [31:0] mDataIn;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .CLK(CLK), .Reset(Reset), .Req(Req), .MemWrite(MemWrite), .Size(Size),
        .SignExt(SignExt), .Addr(Addr), .WData(WData), .Busy(Busy), .Done(Done),
        .RData(RData), .Fault(Fault), .mRD(mRD), .mWR(mWR), .mAddr(mAddr),
        .mDataOut(mDataOut), .mDataIn(mDataIn)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Attached memory: combinational read while mRD low, write on the edge ending an mWR-low cycle.
    logic [31:0] pm [NWORDS];
    logic [29:0] widx;
    assign widx    = mAddr[31:2];
    assign mDataIn = (!mRD && widx < 30'(NWORDS)) ? pm[widx] : 32'hDEAD_BEEF;
    always @(posedge CLK) begin
        if (!mWR && widx < 30'(NWORDS)) pm[widx] = mDataOut;
    end

    // Reference: byte-addressed big-endian memory and the expected outcome of the current access.
    logic [7:0]  mb [MEM_BYTES];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          t_active, t_legal, t_write, t_alt_ok, alt_ok, ed;
    int          t_start, t_done, rd_cnt, wr_cnt, done_seen;
    logic        fault_seen;
    logic [31:0] t_rdata, t_alt, t_maddr, t_wword, exp_rdata, exp_alt;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of every output against the reference.
    always @(negedge CLK) begin
        if (!Reset) begin
            ed = t_active && (cyc == t_done);
            if (ed && t_legal && !t_write) begin
                exp_rdata = t_rdata;
                exp_alt   = t_alt;
                alt_ok    = t_alt_ok;
            end
            chk("done", 32'(Done), 32'(ed));
            chk("busy", 32'(Busy), 32'(t_active && cyc >= t_start && cyc <= t_done));
            chk("fault", 32'(Fault), 32'(ed && !t_legal));
            n_cmp++;
            if (!(RData === exp_rdata || (alt_ok && RData === exp_alt))) begin
                n_bad++;
                $display("FAIL rdata: got 0x%08h expected 0x%08h (cycle %0d)", RData, exp_rdata, cyc);
            end
            n_cmp++;
            if (!mRD && !mWR) begin
                n_bad++;
                $display("FAIL strobes: mRD=%b mWR=%b both low (cycle %0d)", mRD, mWR, cyc);
            end
            if (Done) begin
                done_seen  = cyc;
                fault_seen = Fault;
            end
            if (!mRD) begin
                rd_cnt++;
                chk("rd_addr", mAddr, t_maddr);
            end
            if (!mWR) begin
                wr_cnt++;
                chk("wr_addr", mAddr, t_maddr);
                chk("wr_data", mDataOut, t_wword);
            end
        end
    end

    // Issue one request; the reference outcome is computed from the byte memory.
    task automatic start(input bit w, input logic [1:0] sz, input bit sx, input logic [31:0] a,
                         input logic [31:0] wd, input bit hold, input bit use_alt,
                         input logic [31:0] alt);
        longint      la, wa;
        int          ia, iw;
        int unsigned v;
        @(negedge CLK); #1;
        la = longint'(a);
        wa = la - (la % 4);
        t_legal = (sz != 2'b11) && !(sz == 2'b01 && la % 2 != 0) && !(sz == 2'b10 && la % 4 != 0)
                  && (wa + 3 <= longint'(MEM_BYTES) - 1);
        t_write = w;
        t_start = cyc + 1;
        t_done  = t_start + (!t_legal ? 0 : (w ? 2 : 1));
        if (t_legal) begin
            ia = int'(la);
            iw = int'(wa);
            t_maddr = 32'(wa);
            if (w) begin
                case (sz)
                    2'b00: mb[ia] = wd[7:0];
                    2'b01: begin mb[ia] = wd[15:8]; mb[ia+1] = wd[7:0]; end
                    default: begin
                        mb[iw] = wd[31:24]; mb[iw+1] = wd[23:16];
                        mb[iw+2] = wd[15:8]; mb[iw+3] = wd[7:0];
                    end
                endcase
                t_wword = {mb[iw], mb[iw+1], mb[iw+2], mb[iw+3]};
            end else begin
                case (sz)
                    2'b00: begin
                        v = mb[ia];
                        if (sx && v >= 128) v = v - 256;
                    end
                    2'b01: begin
                        v = mb[ia] * 256 + mb[ia+1];
                        if (sx && v >= 32768) v = v - 65536;
                    end
                    default: v = ((mb[iw] * 256 + mb[iw+1]) * 256 + mb[iw+2]) * 256 + mb[iw+3];
                endcase
                t_rdata = v;
            end
        end
        t_alt = alt;
        t_alt_ok = use_alt;
        rd_cnt = 0;
        wr_cnt = 0;
        done_seen = -1;
        fault_seen = 1'b0;
        t_active = 1'b1;
        Req = 1'b1; MemWrite = w; Size = sz; SignExt = sx; Addr = a; WData = wd;
        @(negedge CLK); #1;
        Req = hold; MemWrite = ~w; Size = ~sz; SignExt = ~sx; Addr = ~a; WData = ~wd;
    endtask

    task automatic finish_access(output int lat);
        int k;
        k = 0;
        while (cyc <= t_done && k < 12) begin
            @(negedge CLK); #1;
            k++;
        end
        Req = 1'b0;
        n_cmp++;
        if (cyc <= t_done) begin
            n_bad++;
            $display("FAIL timeout: access started at cycle %0d not finished", t_start);
        end
        chk("rd_strobes", 32'(rd_cnt), 32'(t_legal));
        chk("wr_strobes", 32'(wr_cnt), 32'(t_legal && t_write));
        if (t_legal && t_write) chk("mem_word", pm[t_maddr[31:2]], t_wword);
        lat = done_seen - t_start + 1;
    endtask

    task automatic access(input bit w, input logic [1:0] sz, input bit sx, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold, output int lat);
        start(w, sz, sx, a, wd, hold, 1'b0, 32'h0);
        finish_access(lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] w, old;
        Reset = 1'b1; Req = 1'b0; MemWrite = 1'b0; Size = 2'b00; SignExt = 1'b0;
        Addr = '0; WData = '0;
        t_active = 1'b0; alt_ok = 1'b0; t_alt_ok = 1'b0; exp_rdata = '0; exp_alt = '0;
        t_start = 0; t_done = -1; t_maddr = '0; t_wword = '0;
        for (int i = 0; i < int'(NWORDS); i++) pm[i] = 32'(i) * 32'h0101_0107 ^ 32'h5A5A_A5A5;
        pm[4] = 32'h1122_3344;
        pm[5] = 32'h80FF_0000;
        for (int i = 0; i < int'(NWORDS); i++) begin
            w = pm[i];
            mb[4*i] = w[31:24]; mb[4*i+1] = w[23:16]; mb[4*i+2] = w[15:8]; mb[4*i+3] = w[7:0];
        end

        repeat (2) @(negedge CLK);
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_fault", 32'(Fault), 32'd0);
        chk("rst_mrd", 32'(mRD), 32'd1);
        chk("rst_mwr", 32'(mWR), 32'd1);
        chk("rst_maddr", mAddr, 32'h0);
        chk("rst_mdataout", mDataOut, 32'h0);
        chk("rst_rdata", RData, 32'h0);
        Reset = 1'b0;

        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, lat);
        chk("pin_word_load", RData, 32'h1122_3344);
        chk("pin_load_latency", 32'(lat), 32'd2);
        access(1'b0, 2'b00, 1'b1, 32'h14, 32'h0, 1'b0, lat);
        chk("pin_sbyte", RData, 32'hFFFF_FF80);
        access(1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 1'b0, lat);
        chk("pin_ubyte", RData, 32'h0000_0080);
        access(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 1'b0, lat);
        chk("pin_uhalf", RData, 32'h0000_80FF);
        access(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 1'b0, lat);
        chk("pin_shalf", RData, 32'hFFFF_80FF);
        access(1'b0, 2'b00, 1'b1, 32'h15, 32'h0, 1'b0, lat);
        access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, lat);
        chk("pin_ubyte_off3", RData, 32'h0000_0044);

        access(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_ABCD, 1'b0, lat);
        chk("pin_half_store", pm[4], 32'h1122_ABCD);
        chk("pin_store_latency", 32'(lat), 32'd3);
        chk("pin_store_keeps_rdata", RData, 32'h0000_0044);
        access(1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_56EE, 1'b0, lat);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, lat);
        chk("pin_byte_store", RData, 32'h11EE_ABCD);

        access(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b0, lat);
        chk("pin_fault_latency", 32'(lat), 32'd1);
        chk("pin_fault_flag", 32'(fault_seen), 32'd1);
        access(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0, lat);
        chk("pin_fault_size", 32'(fault_seen), 32'd1);
        access(1'b0, 2'b10, 1'b0, 32'h190, 32'h0, 1'b0, lat);
        chk("pin_fault_range", 32'(fault_seen), 32'd1);
        access(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 1'b0, lat);
        access(1'b1, 2'b10, 1'b0, 32'h190, 32'h5555_5555, 1'b0, lat);
        access(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, lat);
        chk("pin_fault_keeps_rdata", RData, 32'h11EE_ABCD);

        access(1'b0, 2'b10, 1'b0, 32'h18C, 32'h0, 1'b0, lat);
        access(1'b1, 2'b10, 1'b0, 32'h18C, 32'hA5A5_0F0F, 1'b0, lat);
        access(1'b0, 2'b10, 1'b0, 32'h18C, 32'h0, 1'b0, lat);
        chk("pin_last_word", RData, 32'hA5A5_0F0F);

        access(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b1, lat);
        chk("pin_busy_ignore", RData, 32'h80FF_0000);
        access(1'b1, 2'b00, 1'b0, 32'h1B, 32'h0000_0077, 1'b1, lat);

        // Reset in the write cycle of a store: the memory word may end up old or new.
        old = {mb[32], mb[33], mb[34], mb[35]};
        start(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
        @(negedge CLK); #1;
        chk("pre_reset_mwr", 32'(mWR), 32'd0);
        #1;
        Reset = 1'b1;
        Req = 1'b1;
        t_active = 1'b0;
        alt_ok = 1'b0;
        exp_rdata = '0;
        #1;
        chk("async_mwr", 32'(mWR), 32'd1);
        chk("async_busy", 32'(Busy), 32'd0);
        chk("async_done", 32'(Done), 32'd0);
        chk("async_mrd", 32'(mRD), 32'd1);
        chk("async_rdata", RData, 32'h0);
        repeat (2) @(negedge CLK);
        #1;
        Req = 1'b0;
        Reset = 1'b0;
        repeat (3) @(negedge CLK);
        start(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, old);
        finish_access(lat);
        n_cmp++;
        if (RData !== 32'hCAFE_F00D && RData !== old) begin
            n_bad++;
            $display("FAIL reset_word: got 0x%08h expected 0xcafef00d or 0x%08h", RData, old);
        end
        access(1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678, 1'b0, lat);
        access(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, lat);
        chk("pin_after_reset", RData, 32'h0000_5678);

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_BYTES, default 400, SHALL be the byte size of the attached data memory; valid byte addresses are 0..MEM_BYTES-1.
REQ-002 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Req  input  1  access request, sampled only in IDLE.
REQ-005 MemWrite  input  1  1 = store, 0 = load.
REQ-006 Size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-007 SignExt  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 Addr  input  32  byte address of the access.
REQ-009 WData  input  32  store data, right-aligned.
REQ-010 Busy  output  1  high whenever the state is not IDLE.
REQ-011 Done  output  1  one-cycle completion pulse.
REQ-012 RData  output  32  load result, right-aligned and extended.
REQ-013 Fault  output  1  asserted together with Done when an access is rejected.
REQ-014 mRD  output  1  active-low read strobe to data memory.
REQ-015 mWR  output  1  active-low write strobe to data memory.
REQ-016 mAddr  output  32  word-aligned address to data memory.
REQ-017 mDataOut  output  32  write word to data memory.
REQ-018 mDataIn  input  32  read word from data memory, big-endian: byte offset 0 = bits 31:24.

Function
REQ-019 The block SHALL implement the FSM IDLE, READ, WRITE and DONE.
REQ-020 IDLE & Req SHALL latch MemWrite, Size, SignExt, Addr and WData; later input changes SHALL be ignored until the next IDLE.
REQ-021 Legality SHALL be checked at acceptance; an access is illegal when Size=11, or a halfword has Addr[0]=1, or a word has Addr[1:0]!=0, or (Addr & ~3)+3 > MEM_BYTES-1.
REQ-022 Illegal access: IDLE->DONE with Fault=1; mRD and mWR SHALL stay 1; RData SHALL be unchanged.
REQ-023 Legal access: IDLE->READ with mAddr = Addr & ~3 and mRD=0 for exactly one cycle; the word on mDataIn SHALL be captured on the exiting edge.
REQ-024 Legal load: READ->DONE; RData SHALL be loaded on that edge with the selected byte/half/word, extended per SignExt.
REQ-025 Legal store: READ->WRITE; mDataOut SHALL be the captured word with the addressed byte/half (or the whole word) replaced by WData[7:0], WData[15:0] or WData[31:0]; mWR=0 for exactly one cycle.
REQ-026 WRITE->DONE unconditionally.
REQ-027 DONE: Done=1 for one cycle, then ->IDLE; Req high in DONE SHALL be ignored.
REQ-028 Latency from the edge sampling Req to Done high SHALL be: load 2 cycles, store 3 cycles, illegal access 1 cycle.
REQ-029 mRD, mWR, mAddr and mDataOut SHALL be driven directly from flops with no glitches, because the memory acts on any input change while a strobe is low.
REQ-030 mAddr and mDataOut SHALL be stable for the whole cycle in which mWR=0; mRD and mWR SHALL never be 0 together.
REQ-031 RData SHALL hold its value until the next successful load; stores SHALL NOT modify it.

Reset
REQ-032 Reset=1 SHALL immediately force IDLE, Busy=0, Done=0, Fault=0, mRD=1, mWR=1, mAddr=0, mDataOut=0 and RData=0, including when it arrives mid-READ or mid-WRITE.
REQ-033 A request pending at reset SHALL be discarded; the first Req accepted is the one sampled on the first edge after Reset falls.

Verification
REQ-034 Load: memory word 0x10 = 0x11223344; word load at 0x10 -> RData=0x11223344, Done 2 cycles after Req, Fault=0.
REQ-035 Load extend: word 0x14 = 0x80FF0000; signed byte load at 0x14 -> 0xFFFFFF80; unsigned -> 0x00000080; unsigned halfword at 0x14 -> 0x000080FF.
REQ-036 Store: halfword store of WData=0x0000ABCD at 0x12 over 0x11223344 -> memory word 0x10 = 0x1122ABCD, mWR low exactly one cycle, Done 3 cycles after Req.
REQ-037 Faults: word load at 0x11, Size=11 at 0x10, and word load at 0x190 each -> Fault=1 with Done 1 cycle after Req; mRD and mWR never low.
REQ-038 Reset during WRITE: mWR=1 asynchronously, Busy=0, no Done pulse; a following load of the same word returns either the old or the new word, with no other value allowed.
REQ-039 Busy ignore: Req pulsed during READ and DONE of a load -> exactly one Done pulse and one memory access.
